// File: rtl/alu_defs_pkg.sv
// Shared ALU op codes, R-type funct codes, FSM encoding and the R-type decoder
// used by the alu_issue_wb issue/write-back stage.
package alu_defs;

  localparam logic [2:0] ALUOP_ADDU = 3'b000;
  localparam logic [2:0] ALUOP_SUBU = 3'b001;
  localparam logic [2:0] ALUOP_AND  = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_SRL  = 3'b100;
  localparam logic [2:0] ALUOP_SRA  = 3'b101;

  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BSEL_RT    = 2'd0,
    BSEL_SHAMT = 2'd1,
    BSEL_RS    = 2'd2,
    BSEL_ZERO  = 2'd3
  } bsel_t;

  typedef struct packed {
    logic [2:0] op;
    logic       a_rt;
    bsel_t      b_sel;
    logic       illegal;
  } ctrl_t;

  // Illegal encodings collapse to ADDU 0+0 so the ALU sees a harmless operation.
  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c.op      = ALUOP_ADDU;
    c.a_rt    = 1'b0;
    c.b_sel   = BSEL_RT;
    c.illegal = 1'b0;
    case (funct)
      FUNCT_ADDU: c.op = ALUOP_ADDU;
      FUNCT_SUBU: c.op = ALUOP_SUBU;
      FUNCT_AND:  c.op = ALUOP_AND;
      FUNCT_OR:   c.op = ALUOP_OR;
      FUNCT_SRL:  begin c.op = ALUOP_SRL; c.a_rt = 1'b1; c.b_sel = BSEL_SHAMT; end
      FUNCT_SRA:  begin c.op = ALUOP_SRA; c.a_rt = 1'b1; c.b_sel = BSEL_SHAMT; end
      FUNCT_SRLV: begin c.op = ALUOP_SRL; c.a_rt = 1'b1; c.b_sel = BSEL_RS;    end
      FUNCT_SRAV: begin c.op = ALUOP_SRA; c.a_rt = 1'b1; c.b_sel = BSEL_RS;    end
      default:    c.illegal = 1'b1;
    endcase
    if (opcode != 6'd0 || c.illegal) begin
      c.op      = ALUOP_ADDU;
      c.a_rt    = 1'b0;
      c.b_sel   = BSEL_ZERO;
      c.illegal = 1'b1;
    end else begin
      c.illegal = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/grf.sv
// 32-entry general register file: two combinational read ports, a debug read
// port and one synchronous write port; register 0 always reads as zero.
module grf #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    ra1,
  input  logic [4:0]    ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [4:0]    wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == 5'd0)      ? '0 : regs[ra1];
  assign rd2      = (ra2 == 5'd0)      ? '0 : regs[ra2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/write-back stage around an external combinational ALU: accepts one
// R-type instruction, runs it through IDLE -> EXEC -> WB and writes rd.
module alu_issue_wb
  import alu_defs::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_C,
  output logic          wb_valid,
  output logic [4:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          err,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state, state_next;
  ctrl_t         ctrl;
  logic [DW-1:0] rs_val, rt_val, a_next, b_next;
  logic [4:0]    dest;
  logic          illegal;
  logic          accept;
  logic          gpr_we;

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign ctrl        = decode(instr[31:26], instr[5:0]);
  assign gpr_we      = (state == ST_WB) && wb_valid;

  grf #(.NREG(NREG), .DW(DW)) u_grf (
    .clk      (clk),
    .reset    (reset),
    .ra1      (instr[25:21]),
    .ra2      (instr[20:16]),
    .rd1      (rs_val),
    .rd2      (rt_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (gpr_we),
    .wa       (wb_addr),
    .wd       (wb_data)
  );

  always_comb begin
    a_next = ctrl.illegal ? '0 : (ctrl.a_rt ? rt_val : rs_val);
    b_next = '0;
    case (ctrl.b_sel)
      BSEL_RT:    b_next = rt_val;
      BSEL_SHAMT: b_next = {{(DW-5){1'b0}}, instr[10:6]};
      BSEL_RS:    b_next = {{(DW-5){1'b0}}, rs_val[4:0]};
      default:    b_next = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = accept ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // wb_valid/err are set at the edge ending EXEC so they are high exactly during WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_A    <= '0;
      alu_B    <= '0;
      alu_op   <= ALUOP_ADDU;
      dest     <= 5'd0;
      illegal  <= 1'b0;
      wb_data  <= '0;
      wb_addr  <= 5'd0;
      wb_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      if (accept) begin
        alu_A   <= a_next;
        alu_B   <= b_next;
        alu_op  <= ctrl.op;
        dest    <= instr[15:11];
        illegal <= ctrl.illegal;
      end
      if (state == ST_EXEC) begin
        wb_data  <= alu_C;
        wb_addr  <= dest;
        wb_valid <= !illegal;
        err      <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Self-checking bench for alu_issue_wb: a behavioural ALU closes the loop and a
// scoreboard of expected write-backs is compared against each retirement.
module tb_alu_issue_wb;

  localparam logic [5:0] F_SRL = 6'h02, F_SRA = 6'h03, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_A, alu_B, alu_C;
  logic [2:0]  alu_op;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        ovr_en;
  logic [31:0] ovr_val;

  typedef struct packed {
    logic        legal;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] dbg;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] gm [32];
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] p_ins [16];
  logic        p_ov  [16];
  logic [31:0] p_val [16];
  int          p_n;

  int          obs_lat;
  logic        obs_wbv, obs_err, obs_ready, obs_after;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_dbg;

  alu_issue_wb #(.NREG(32), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_C       (alu_C),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; the override lets the bench seed register values.
  always_comb begin
    case (alu_op)
      3'b000:  alu_C = alu_A + alu_B;
      3'b001:  alu_C = alu_A - alu_B;
      3'b010:  alu_C = alu_A & alu_B;
      3'b011:  alu_C = alu_A | alu_B;
      3'b100:  alu_C = alu_A >> alu_B[4:0];
      3'b101:  alu_C = $signed(alu_A) >>> alu_B[4:0];
      default: alu_C = 32'h0;
    endcase
    if (ovr_en) alu_C = ovr_val;
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic is_legal(input logic [31:0] ins);
    if (ins[31:26] != 6'd0) return 1'b0;
    case (ins[5:0])
      F_SRL, F_SRA, F_SRLV, F_SRAV, F_ADDU, F_SUBU, F_AND, F_OR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [31:0] ins);
    logic [31:0] a, b;
    logic [4:0]  sh;
    a  = gm[ins[25:21]];
    b  = gm[ins[20:16]];
    sh = ins[10:6];
    case (ins[5:0])
      F_ADDU:  return a + b;
      F_SUBU:  return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_SRL:   return b >> sh;
      F_SRA:   return $signed(b) >>> sh;
      F_SRLV:  return b >> a[4:0];
      F_SRAV:  return $signed(b) >>> a[4:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic add(input logic [31:0] ins, input logic ov, input logic [31:0] val);
    p_ins[p_n] = ins;
    p_ov[p_n]  = ov;
    p_val[p_n] = val;
    p_n++;
  endtask

  task automatic seed(input logic [4:0] r, input logic [31:0] val);
    add(rtype(5'd0, 5'd0, r, 5'd0, F_ADDU), 1'b1, val);
  endtask

  task automatic step(input logic [31:0] ins, input logic ov, input logic [31:0] ov_val);
    sb_t e;
    @(negedge clk);
    for (int i = 0; i < 8 && instr_ready !== 1'b1; i++) @(negedge clk);
    e.legal = is_legal(ins);
    e.addr  = ins[15:11];
    e.data  = ov ? ov_val : model(ins);
    if (e.legal && e.addr != 5'd0) gm[e.addr] = e.data;
    e.dbg = gm[e.addr];
    sb.push_back(e);
    instr = ins; instr_valid = 1'b1; ovr_en = ov; ovr_val = ov_val; dbg_addr = ins[15:11];
    @(posedge clk);
    #1 instr_valid = 1'b0;
    obs_lat = 0; obs_wbv = 1'b0; obs_err = 1'b0; obs_addr = 5'd0; obs_data = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (wb_valid || err) begin
        obs_lat = c; obs_wbv = wb_valid; obs_err = err; obs_addr = wb_addr; obs_data = wb_data;
        break;
      end
    end
    @(negedge clk);
    obs_dbg = dbg_data; obs_ready = instr_ready; obs_after = wb_valid | err;
    ovr_en = 1'b0;
  endtask

  task automatic run_program(input string nm);
    sb_t e;
    for (int k = 0; k < p_n; k++) begin
      step(p_ins[k], p_ov[k], p_val[k]);
      e = sb.pop_front();
      vectors++;
      if (obs_lat !== 2) begin
        miscompares++; $display("FAIL %s[%0d] latency got %0d want 2", nm, k, obs_lat);
      end
      vectors++;
      if (obs_wbv !== e.legal || obs_err !== !e.legal) begin
        miscompares++;
        $display("FAIL %s[%0d] wb_valid/err got %b/%b want %b/%b", nm, k, obs_wbv, obs_err, e.legal, !e.legal);
      end
      if (e.legal) begin
        vectors++;
        if (obs_addr !== e.addr || obs_data !== e.data) begin
          miscompares++;
          $display("FAIL %s[%0d] wb addr/data got %0d/%h want %0d/%h", nm, k, obs_addr, obs_data, e.addr, e.data);
        end
      end
      vectors++;
      if (obs_dbg !== e.dbg) begin
        miscompares++; $display("FAIL %s[%0d] gpr r%0d got %h want %h", nm, k, e.addr, obs_dbg, e.dbg);
      end
      vectors++;
      if (obs_ready !== 1'b1 || obs_after !== 1'b0) begin
        miscompares++;
        $display("FAIL %s[%0d] after-wb ready/pulse got %b/%b want 1/0", nm, k, obs_ready, obs_after);
      end
    end
    p_n = 0;
  endtask

  task automatic check_reg(input string nm, input logic [4:0] r, input logic [31:0] want);
    dbg_addr = r;
    #1;
    vectors++;
    if (dbg_data !== want) begin
      miscompares++; $display("FAIL %s r%0d got %h want %h", nm, r, dbg_data, want);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl ready/wb_valid/err got %b/%b/%b want 1/0/0", instr_ready, wb_valid, err);
    end
    vectors++;
    if (alu_A !== 32'h0 || alu_B !== 32'h0 || alu_op !== 3'b000) begin
      miscompares++; $display("FAIL reset_alu A/B/op got %h/%h/%b want 0/0/000", alu_A, alu_B, alu_op);
    end
    vectors++;
    if (wb_addr !== 5'd0 || wb_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_wb addr/data got %0d/%h want 0/0", wb_addr, wb_data);
    end
    check_reg("reset_gpr", 5'd1, 32'h0);
    check_reg("reset_gpr", 5'd31, 32'h0);
  endtask

  task automatic test_addu();
    p_n = 0;
    seed(5'd1, 32'd5);
    seed(5'd2, 32'd7);
    add(rtype(5'd1, 5'd2, 5'd3, 5'd0, F_ADDU), 1'b0, 32'h0);
    run_program("addu");
    check_reg("addu_r3", 5'd3, 32'd12);
  endtask

  task automatic test_subu_shift();
    p_n = 0;
    seed(5'd1, 32'd0);
    seed(5'd2, 32'd1);
    add(rtype(5'd1, 5'd2, 5'd4, 5'd0, F_SUBU), 1'b0, 32'h0);
    add(rtype(5'd0, 5'd4, 5'd5, 5'd4, F_SRA), 1'b0, 32'h0);
    add(rtype(5'd0, 5'd4, 5'd6, 5'd28, F_SRL), 1'b0, 32'h0);
    add(rtype(5'd4, 5'd6, 5'd15, 5'd0, F_AND), 1'b0, 32'h0);
    run_program("subu_shift");
    check_reg("subu_wrap", 5'd4, 32'hFFFF_FFFF);
    check_reg("sra_imm", 5'd5, 32'hFFFF_FFFF);
    check_reg("srl_imm", 5'd6, 32'h0000_000F);
  endtask

  task automatic test_var_shift();
    p_n = 0;
    seed(5'd10, 32'h0000_0024);
    seed(5'd11, 32'h8000_0000);
    add(rtype(5'd10, 5'd11, 5'd12, 5'd0, F_SRAV), 1'b0, 32'h0);
    add(rtype(5'd10, 5'd11, 5'd13, 5'd0, F_SRLV), 1'b0, 32'h0);
    run_program("var_shift");
    check_reg("srav_mask", 5'd12, 32'hF800_0000);
    check_reg("srlv_mask", 5'd13, 32'h0800_0000);
  endtask

  task automatic test_zero_reg();
    p_n = 0;
    seed(5'd1, 32'd3);
    seed(5'd2, 32'd4);
    add(rtype(5'd1, 5'd2, 5'd0, 5'd0, F_ADDU), 1'b0, 32'h0);
    add(rtype(5'd0, 5'd1, 5'd7, 5'd0, F_OR), 1'b0, 32'h0);
    run_program("zero_reg");
    check_reg("zero_r0", 5'd0, 32'h0);
    check_reg("zero_or", 5'd7, 32'd3);
  endtask

  task automatic test_illegal();
    p_n = 0;
    seed(5'd14, 32'h0000_1234);
    add({6'h08, 5'd1, 5'd2, 5'd14, 5'd0, F_ADDU}, 1'b0, 32'h0);
    add(rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h20), 1'b0, 32'h0);
    run_program("illegal");
    check_reg("illegal_nowrite", 5'd14, 32'h0000_1234);
  endtask

  task automatic test_reset_midop();
    int pulses;
    p_n = 0;
    seed(5'd1, 32'd5);
    seed(5'd2, 32'd7);
    run_program("midop_seed");
    @(negedge clk);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, F_ADDU); instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) gm[i] = 32'h0;
    vectors++;
    if (instr_ready !== 1'b1 || alu_A !== 32'h0 || alu_B !== 32'h0) begin
      miscompares++; $display("FAIL midop_state ready/A/B got %b/%h/%h want 1/0/0", instr_ready, alu_A, alu_B);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid || err) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++; $display("FAIL midop_pulses got %0d want 0", pulses);
    end
    check_reg("midop_r3", 5'd3, 32'h0);
    check_reg("midop_r1", 5'd1, 32'h0);
  endtask

  task automatic test_back_to_back();
    sb_t e;
    int  acc, wbs, prev;
    p_n = 0;
    seed(5'd9, 32'd1);
    seed(5'd8, 32'd0);
    run_program("b2b_seed");
    acc = 0; wbs = 0; prev = -1;
    @(negedge clk);
    instr = rtype(5'd8, 5'd9, 5'd8, 5'd0, F_ADDU); instr_valid = 1'b1; dbg_addr = 5'd8;
    for (int cyc = 0; cyc < 19; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 15) instr_valid = 1'b0;
      if (wb_valid) begin
        wbs++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL b2b_wb unexpected write r%0d=%h", wb_addr, wb_data);
        end else begin
          e = sb.pop_front();
          if (wb_addr !== e.addr || wb_data !== e.data) begin
            miscompares++;
            $display("FAIL b2b_wb addr/data got %0d/%h want %0d/%h", wb_addr, wb_data, e.addr, e.data);
          end
        end
      end
      if (instr_ready && instr_valid) begin
        if (prev >= 0) begin
          vectors++;
          if (cyc - prev !== 3) begin
            miscompares++; $display("FAIL b2b_spacing got %0d want 3", cyc - prev);
          end
        end
        prev = cyc; acc++;
        e.legal = 1'b1; e.addr = 5'd8; e.data = gm[8] + gm[9]; gm[8] = e.data; e.dbg = e.data;
        sb.push_back(e);
      end
    end
    vectors++;
    if (acc !== 5 || wbs !== 5 || sb.size() !== 0) begin
      miscompares++; $display("FAIL b2b_counts accepts/writes/pending got %0d/%0d/%0d want 5/5/0", acc, wbs, sb.size());
    end
    check_reg("b2b_r8", 5'd8, 32'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
    ovr_en = 1'b0; ovr_val = 32'h0; p_n = 0;
    for (int i = 0; i < 32; i++) gm[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_addu();
    test_subu_shift();
    test_var_shift();
    test_zero_reg();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
